// File: rtl/seg7_scan_mux.sv
// Four-digit scan controller for a common-anode seven-segment display.
// Double-buffers the hex value so updates only land at frame boundaries.
module seg7_scan_mux #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_data,
  input  logic        i_load,
  input  logic [3:0]  i_dig_en,
  input  logic [3:0]  i_dp_in,
  input  logic        i_blank_lz,
  output logic [3:0]  o_hex,
  output logic [3:0]  o_an,
  output logic        o_dp,
  output logic        o_pending,
  output logic        o_frame_done
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_shadow;
  logic [15:0]      r_active;
  logic             r_pending;
  logic             r_wrapped;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_idx_nxt;
  logic [15:0]      w_shadow_nxt;
  logic [15:0]      w_active_nxt;
  logic             w_pending_nxt;
  logic             w_slot_end;
  logic             w_wrap;

  logic [3:0]       w_nib;
  logic             w_lz;
  logic             w_lit;
  logic [3:0]       w_an_nxt;
  logic             w_dp_nxt;

  // Slot counter, digit index and shadow/active buffering.
  always_comb begin
    w_cnt_nxt     = r_cnt + CNT_W'(1);
    w_idx_nxt     = r_idx;
    w_shadow_nxt  = r_shadow;
    w_active_nxt  = r_active;
    w_pending_nxt = r_pending;
    w_slot_end    = (r_cnt == CNT_LAST);
    w_wrap        = w_slot_end && (r_idx == 2'd3);

    if (w_slot_end) begin
      w_cnt_nxt = '0;
      w_idx_nxt = r_idx + 2'd1;
    end

    if (i_load) begin
      w_shadow_nxt  = i_data;
      w_pending_nxt = 1'b1;
    end

    // A load landing on the wrap goes straight to the active buffer.
    if (w_wrap) begin
      if (i_load) begin
        w_active_nxt  = i_data;
        w_pending_nxt = 1'b0;
      end else if (r_pending) begin
        w_active_nxt  = r_shadow;
        w_pending_nxt = 1'b0;
      end
    end
  end

  // Digit selection from the current slot and live enables.
  always_comb begin
    w_nib = r_active[3:0];
    w_lz  = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nib = r_active[3:0];
        w_lz  = 1'b0;
      end
      2'd1: begin
        w_nib = r_active[7:4];
        w_lz  = (r_active[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib = r_active[11:8];
        w_lz  = (r_active[15:8] == 8'h00);
      end
      default: begin
        w_nib = r_active[15:12];
        w_lz  = (r_active[15:12] == 4'h0);
      end
    endcase

    w_lit    = i_dig_en[r_idx] && (r_cnt >= CNT_BLANK) && !(i_blank_lz && w_lz);
    w_an_nxt = 4'b1111;
    w_dp_nxt = 1'b1;
    if (w_lit) begin
      w_an_nxt = ~(4'b0001 << r_idx);
      w_dp_nxt = ~i_dp_in[r_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_shadow     <= 16'h0000;
      r_active     <= 16'h0000;
      r_pending    <= 1'b0;
      r_wrapped    <= 1'b0;
      o_hex        <= 4'h0;
      o_an         <= 4'b1111;
      o_dp         <= 1'b1;
      o_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_shadow     <= w_shadow_nxt;
      r_active     <= w_active_nxt;
      r_pending    <= w_pending_nxt;
      r_wrapped    <= w_wrap;
      o_hex        <= w_nib;
      o_an         <= w_an_nxt;
      o_dp         <= w_dp_nxt;
      // Pulses alongside the first (blanked) output of digit 0.
      o_frame_done <= r_wrapped;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized + directed bench for seg7_scan_mux against a frame-position model.
module tb_seg7_scan_mux;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * RD;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic        load;
  logic [3:0]  dig_en;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  hex;
  logic [3:0]  an;
  logic        dp;
  logic        pending;
  logic        frame_done;

  seg7_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (data),
    .i_load       (load),
    .i_dig_en     (dig_en),
    .i_dp_in      (dp_in),
    .i_blank_lz   (blank_lz),
    .o_hex        (hex),
    .o_an         (an),
    .o_dp         (dp),
    .o_pending    (pending),
    .o_frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Model state: position within the frame plus the two buffers.
  int          m_pos;
  logic [15:0] m_shadow;
  logic [15:0] m_active;
  bit          m_pending;
  bit          m_wrap_last;
  int          cyc;
  int          last_fd;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    logic [3:0] e_hex, e_an;
    logic       e_dp, e_fd;
    int         idx, cnt;
    bit         lz, lit, wrap;
    if (!rst_n) begin
      e_hex = 4'h0; e_an = 4'hF; e_dp = 1'b1; e_fd = 1'b0;
      m_pos = 0; m_shadow = 16'h0; m_active = 16'h0;
      m_pending = 0; m_wrap_last = 0; last_fd = -1;
    end else begin
      idx   = m_pos / RD;
      cnt   = m_pos % RD;
      e_hex = 4'((m_active >> (4 * idx)) & 16'hF);
      lz    = blank_lz && (idx >= 1) && ((m_active >> (4 * idx)) == 16'h0);
      lit   = dig_en[idx] && (cnt >= BC) && !lz;
      e_an  = lit ? ~(4'(1 << idx)) : 4'hF;
      e_dp  = lit ? ~dp_in[idx] : 1'b1;
      e_fd  = m_wrap_last;
      wrap  = (m_pos == FRAME - 1);
      if (load) begin
        m_shadow  = data;
        m_pending = 1;
      end
      if (wrap && load) begin
        m_active  = data;
        m_pending = 0;
      end else if (wrap && m_pending) begin
        m_active  = m_shadow;
        m_pending = 0;
      end
      m_pos       = (m_pos + 1) % FRAME;
      m_wrap_last = wrap;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_eq("hex", 16'(hex), 16'(e_hex));
    check_eq("an", 16'(an), 16'(e_an));
    check_eq("dp", 16'(dp), 16'(e_dp));
    check_eq("pending", 16'(pending), 16'(m_pending));
    check_eq("frame_done", 16'(frame_done), 16'(e_fd));
    if (frame_done === 1'b1) begin
      if (last_fd >= 0) check_eq("fd_period", 16'(cyc - last_fd), 16'(FRAME));
      last_fd = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_load(input logic [15:0] d);
    data = d;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Advance until the next edge will be taken at frame position p.
  task automatic go_to_pos(input int p);
    int guard = 0;
    while (m_pos != p && guard < FRAME + 1) begin
      step();
      guard++;
    end
    if (m_pos != p) begin
      n_vec++;
      n_fail++;
      $display("FAIL go_to_pos: position %0d not reached", p);
    end
  endtask

  initial begin
    cyc = 0; last_fd = -1;
    m_pos = 0; m_shadow = 0; m_active = 0; m_pending = 0; m_wrap_last = 0;
    rst_n = 1'b0; data = 16'h0; load = 1'b0;
    dig_en = 4'hF; dp_in = 4'h0; blank_lz = 1'b0;

    run(2);
    check_eq("reset_an", 16'(an), 16'hF);
    rst_n = 1'b1;

    // Idle scan with everything enabled.
    run(2 * FRAME + 4);

    // Mid-frame load becomes visible next frame.
    go_to_pos(10);
    pulse_load(16'h1A3F);
    check_eq("pend_after_load", 16'(pending), 16'h1);
    run(2 * FRAME);

    // Two loads in one frame, then a load exactly on the wrap edge.
    go_to_pos(3);
    pulse_load(16'h1111);
    run(5);
    pulse_load(16'h2222);
    go_to_pos(FRAME - 1);
    run(FRAME);
    go_to_pos(FRAME - 1);
    pulse_load(16'h5678);
    check_eq("wrap_load_no_pend", 16'(pending), 16'h0);
    run(FRAME);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    pulse_load(16'h0040);
    run(2 * FRAME);
    pulse_load(16'h0000);
    run(2 * FRAME);
    blank_lz = 1'b0;

    // Partial digit enables and decimal point.
    dig_en = 4'b0101;
    dp_in  = 4'b0100;
    pulse_load(16'h9ABC);
    run(2 * FRAME);
    dig_en = 4'hF;
    dp_in  = 4'h0;

    // Reset during digit 2's lit phase with a pending update.
    go_to_pos(2);
    pulse_load(16'hBEEF);
    go_to_pos(2 * RD + 4);
    rst_n = 1'b0;
    step();
    check_eq("mid_reset_an", 16'(an), 16'hF);
    check_eq("mid_reset_pend", 16'(pending), 16'h0);
    rst_n = 1'b1;
    run(FRAME + 2);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      load = ($urandom % 8) == 0;
      data = 16'($urandom);
      if (($urandom % 5) == 0) data = data & 16'h00FF;
      if (($urandom % 16) == 0) begin
        dig_en   = 4'($urandom);
        dp_in    = 4'($urandom);
        blank_lz = 1'($urandom);
      end
      rst_n = (($urandom % 250) != 0);
      step();
    end
    load = 1'b0;
    rst_n = 1'b1;
    run(FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
